ace_rd_arbiter: RTL

// - 2:1 arbiter for the core's single ACE read channel (AR + R).
// - Requester 0 is the instruction fetch unit; requester 1 is the data cache.
// - The grant uses round-robin between the two requesters.
// - Only one read is outstanding at a time, so no ID field is used.
// - The grant is held from AR acceptance until the final R beat (RLAST).
// - Sits between the two L1 caches and the ACE interconnect port.

---
 rtl/ace_rd_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ace_rd_arbiter.sv
// Two-requester round-robin arbiter for a single ACE read channel (AR + R).
// One read is outstanding at a time; the grant is held from AR acceptance until RLAST.
module ace_rd_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int RRESP_WIDTH  = 4,
    parameter int SNOOP_WIDTH  = 4,
    parameter int DOMAIN_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s0_ar_valid,
    output logic                    s0_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   s0_ar_addr,
    input  logic [7:0]              s0_ar_len,
    input  logic [SNOOP_WIDTH-1:0]  s0_ar_snoop,
    input  logic [DOMAIN_WIDTH-1:0] s0_ar_domain,
    output logic                    s0_r_valid,
    input  logic                    s0_r_ready,
    output logic [DATA_WIDTH-1:0]   s0_r_data,
    output logic [RRESP_WIDTH-1:0]  s0_r_resp,
    output logic                    s0_r_last,

    input  logic                    s1_ar_valid,
    output logic                    s1_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   s1_ar_addr,
    input  logic [7:0]              s1_ar_len,
    input  logic [SNOOP_WIDTH-1:0]  s1_ar_snoop,
    input  logic [DOMAIN_WIDTH-1:0] s1_ar_domain,
    output logic                    s1_r_valid,
    input  logic                    s1_r_ready,
    output logic [DATA_WIDTH-1:0]   s1_r_data,
    output logic [RRESP_WIDTH-1:0]  s1_r_resp,
    output logic                    s1_r_last,

    output logic                    m_ar_valid,
    input  logic                    m_ar_ready,
    output logic [ADDR_WIDTH-1:0]   m_ar_addr,
    output logic [7:0]              m_ar_len,
    output logic [SNOOP_WIDTH-1:0]  m_ar_snoop,
    output logic [DOMAIN_WIDTH-1:0] m_ar_domain,

    input  logic                    m_r_valid,
    output logic                    m_r_ready,
    input  logic [DATA_WIDTH-1:0]   m_r_data,
    input  logic [RRESP_WIDTH-1:0]  m_r_resp,
    input  logic                    m_r_last,

    output logic                    protocol_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [SNOOP_WIDTH-1:0]  snoop_q, snoop_d;
    logic [DOMAIN_WIDTH-1:0] domain_q, domain_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic                    protocol_err_q, protocol_err_d;

    logic win;
    logic ar_hs;
    logic in_data;
    logic r_hs;

    // Winner is the sole requester, or on a tie the one that did not go last.
    always_comb begin
        win         = (s0_ar_valid && s1_ar_valid) ? ~last_grant_q : s1_ar_valid;
        s0_ar_ready = (state_q == IDLE) && s0_ar_valid && !win;
        s1_ar_ready = (state_q == IDLE) && s1_ar_valid && win;
        ar_hs       = s0_ar_ready || s1_ar_ready;

        m_ar_valid  = (state_q == ADDR);
        m_ar_addr   = addr_q;
        m_ar_len    = len_q;
        m_ar_snoop  = snoop_q;
        m_ar_domain = domain_q;

        in_data    = (state_q == DATA);
        s0_r_valid = in_data && !grant_q && m_r_valid;
        s0_r_data  = (in_data && !grant_q) ? m_r_data : '0;
        s0_r_resp  = (in_data && !grant_q) ? m_r_resp : '0;
        s0_r_last  = in_data && !grant_q && m_r_last;
        s1_r_valid = in_data && grant_q && m_r_valid;
        s1_r_data  = (in_data && grant_q) ? m_r_data : '0;
        s1_r_resp  = (in_data && grant_q) ? m_r_resp : '0;
        s1_r_last  = in_data && grant_q && m_r_last;
        m_r_ready  = in_data && (grant_q ? s1_r_ready : s0_r_ready);
        r_hs       = in_data && m_r_valid && m_r_ready;

        protocol_err = protocol_err_q;
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        addr_d         = addr_q;
        len_d          = len_q;
        snoop_d        = snoop_q;
        domain_d       = domain_q;
        beat_cnt_d     = beat_cnt_q;
        protocol_err_d = protocol_err_q;

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    addr_d     = win ? s1_ar_addr   : s0_ar_addr;
                    len_d      = win ? s1_ar_len    : s0_ar_len;
                    snoop_d    = win ? s1_ar_snoop  : s0_ar_snoop;
                    domain_d   = win ? s1_ar_domain : s0_ar_domain;
                    grant_d    = win;
                    beat_cnt_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (m_ar_ready) state_d = DATA;
            end
            DATA: begin
                if (r_hs) begin
                    if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
                    // Early RLAST still ends the read; a missing RLAST keeps us waiting for it.
                    if (m_r_last) begin
                        if (beat_cnt_q != len_q) protocol_err_d = 1'b1;
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else if (beat_cnt_q == len_q) begin
                        protocol_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            grant_q        <= 1'b0;
            addr_q         <= '0;
            len_q          <= '0;
            snoop_q        <= '0;
            domain_q       <= '0;
            beat_cnt_q     <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            snoop_q        <= snoop_d;
            domain_q       <= domain_d;
            beat_cnt_q     <= beat_cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

endmodule
